// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a classic 5-stage in-order pipeline. It
// arbitrates between three reasons to disturb the normal flow of instructions:
//   * a data-cache stall, which freezes the whole back end (highest priority),
//   * a load-use hazard, which holds PC and IF/ID for one cycle and injects a
//     bubble into ID/EX,
//   * a taken branch / jump resolved in ID, which squashes the IF/ID entry.
// A flush request that arrives while the back end is frozen is remembered and
// applied on the first cycle the pipeline is allowed to move again.
//
// All state updates on the falling edge of clk_i, the same edge the pipeline
// registers use. Reset is synchronous and active-low.
//
// Parameters
//   TIMEOUT_CYC  consecutive MEM_WAIT cycles after which timeout_o sets
//   CNT_W        width of stall_cnt_o
//
// Ports
//   clk_i            clock (falling-edge active)
//   rst_i            synchronous reset, active-low
//   id_ex_memread_i  load in EX (memread bit of ID/EX)
//   id_ex_rtaddr_i   destination rt of the instruction in EX
//   if_id_rsaddr_i   rs source of the instruction in ID
//   if_id_rtaddr_i   rt source of the instruction in ID
//   if_id_uses_rt_i  ID instruction actually reads rt
//   flush_req_i      branch taken / jump resolved in ID
//   mem_stall_i      dcache busy (miss or write-back)
//   pc_we_o          PC write enable
//   if_id_we_o       IF/ID write enable
//   if_id_flush_o    zero the IF/ID instruction
//   id_ex_bubble_o   force the controls entering ID/EX to zero
//   pipe_hold_o      freeze ID/EX, EX/MEM and MEM/WB
//   stall_cnt_o      saturating count of cycles with pc_we_o = 0
//   timeout_o        sticky dcache-stall timeout flag
//   state_o          current FSM state (0 RUN, 1 MEM_WAIT, 2 RESUME)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rtaddr_i,
  input  logic [4:0]       if_id_rsaddr_i,
  input  logic [4:0]       if_id_rtaddr_i,
  input  logic             if_id_uses_rt_i,
  input  logic             flush_req_i,
  input  logic             mem_stall_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RESUME   = 2'd2
  } state_t;

  // The hold counter must be able to represent TIMEOUT_CYC and is never
  // narrower than 8 bits.
  localparam int HOLD_W_MIN = $clog2(TIMEOUT_CYC + 1);
  localparam int HOLD_W     = (HOLD_W_MIN > 8) ? HOLD_W_MIN : 8;

  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(TIMEOUT_CYC);
  localparam logic [HOLD_W:0]   TIMEOUT_LIM = (HOLD_W + 1)'(TIMEOUT_CYC);

  state_t            state;
  state_t            state_nxt;
  logic              load_use;
  logic              mem_hold;
  logic              pend_flush;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W:0]   hold_inc;
  logic              in_mem_wait;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // r0 is hard-wired to zero, so a load targeting it never creates a hazard.
  // rt only matters when the ID instruction really reads it as a source.
  assign load_use = id_ex_memread_i
                  & (id_ex_rtaddr_i != 5'd0)
                  & ((id_ex_rtaddr_i == if_id_rsaddr_i)
                     | (if_id_uses_rt_i & (id_ex_rtaddr_i == if_id_rtaddr_i)));

  assign in_mem_wait = (state == ST_MEM_WAIT);

  // The back end is frozen both on the cycle the cache first raises its stall
  // (still in RUN/RESUME) and for the whole MEM_WAIT state, including the
  // cycle in which the stall has just dropped.
  assign mem_hold = mem_stall_i | in_mem_wait;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk_i) begin
    if (!rst_i) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = ST_RUN;
    case (state)
      ST_RUN:      state_nxt = mem_stall_i ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT: state_nxt = mem_stall_i ? ST_MEM_WAIT : ST_RESUME;
      ST_RESUME:   state_nxt = mem_stall_i ? ST_MEM_WAIT : ST_RUN;
      default:     state_nxt = ST_RUN;  // unused encoding recovers to RUN
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  // Priority: memory hold > load-use > flush. During reset the pipeline is
  // let through untouched so the datapath reset is not fighting the controller.
  always_comb begin
    pc_we_o        = 1'b1;
    if_id_we_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pipe_hold_o    = 1'b0;

    if (rst_i) begin
      if (mem_hold) begin
        // Whole pipe frozen; no bubble and no flush, since nothing moves.
        pipe_hold_o = 1'b1;
        pc_we_o     = 1'b0;
        if_id_we_o  = 1'b0;
      end else if (load_use) begin
        // Hold the consumer in ID one cycle and send a bubble down. A flush
        // request in this cycle is ignored; the branch is re-resolved when
        // the consumer re-decodes next cycle.
        pc_we_o        = 1'b0;
        if_id_we_o     = 1'b0;
        id_ex_bubble_o = 1'b1;
      end else begin
        if_id_flush_o = flush_req_i | pend_flush;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping: deferred flush, stall-duration watchdog, stall statistics
  // ---------------------------------------------------------------------------
  assign hold_inc = {1'b0, hold_cnt} + (HOLD_W + 1)'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge value of the others and of the
  // combinational outputs, regardless of statement order.
  always_ff @(negedge clk_i) begin
    if (!rst_i) begin
      pend_flush  <= 1'b0;
      hold_cnt    <= '0;
      stall_cnt_o <= '0;
      timeout_o   <= 1'b0;
    end else begin
      // A flush cannot be applied while frozen, so park it. Both conditions
      // are mutually exclusive: if_id_flush_o is always 0 during a hold.
      if (mem_hold && flush_req_i) begin
        pend_flush <= 1'b1;
      end else if (if_id_flush_o) begin
        pend_flush <= 1'b0;
      end

      // Count consecutive MEM_WAIT cycles; restart whenever MEM_WAIT is left.
      // The counter parks at TIMEOUT_CYC so a very long stall cannot wrap.
      if (in_mem_wait && (state_nxt == ST_MEM_WAIT)) begin
        hold_cnt <= (hold_inc >= TIMEOUT_LIM) ? HOLD_MAX : hold_inc[HOLD_W-1:0];
      end else begin
        hold_cnt <= '0;
      end

      // Sticky: once a stall has lasted TIMEOUT_CYC cycles, only reset clears it.
      if (in_mem_wait && (hold_inc >= TIMEOUT_LIM)) begin
        timeout_o <= 1'b1;
      end

      // Saturating count of cycles in which the front end did not advance.
      if (!pc_we_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed self-checking bench for pipe_hazard_ctrl. Two instances share the
// same stimulus: the default configuration, and a small one (TIMEOUT_CYC=3,
// CNT_W=4) that makes timeout and counter saturation cheap to reach.
// Inputs change one ns after the active falling edge; outputs are sampled
// well before the next falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        id_ex_memread_i;
  logic [4:0]  id_ex_rtaddr_i;
  logic [4:0]  if_id_rsaddr_i;
  logic [4:0]  if_id_rtaddr_i;
  logic        if_id_uses_rt_i;
  logic        flush_req_i;
  logic        mem_stall_i;

  logic        pc_we_o, if_id_we_o, if_id_flush_o, id_ex_bubble_o, pipe_hold_o;
  logic [15:0] stall_cnt_o;
  logic        timeout_o;
  logic [1:0]  state_o;

  logic        s_pc_we, s_if_id_we, s_flush, s_bubble, s_hold;
  logic [3:0]  s_stall_cnt;
  logic        s_timeout;
  logic [1:0]  s_state;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_ex_memread_i (id_ex_memread_i),
    .id_ex_rtaddr_i  (id_ex_rtaddr_i),
    .if_id_rsaddr_i  (if_id_rsaddr_i),
    .if_id_rtaddr_i  (if_id_rtaddr_i),
    .if_id_uses_rt_i (if_id_uses_rt_i),
    .flush_req_i     (flush_req_i),
    .mem_stall_i     (mem_stall_i),
    .pc_we_o         (pc_we_o),
    .if_id_we_o      (if_id_we_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_bubble_o  (id_ex_bubble_o),
    .pipe_hold_o     (pipe_hold_o),
    .stall_cnt_o     (stall_cnt_o),
    .timeout_o       (timeout_o),
    .state_o         (state_o)
  );

  pipe_hazard_ctrl #(.TIMEOUT_CYC(3), .CNT_W(4)) dut_small (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_ex_memread_i (id_ex_memread_i),
    .id_ex_rtaddr_i  (id_ex_rtaddr_i),
    .if_id_rsaddr_i  (if_id_rsaddr_i),
    .if_id_rtaddr_i  (if_id_rtaddr_i),
    .if_id_uses_rt_i (if_id_uses_rt_i),
    .flush_req_i     (flush_req_i),
    .mem_stall_i     (mem_stall_i),
    .pc_we_o         (s_pc_we),
    .if_id_we_o      (s_if_id_we),
    .if_id_flush_o   (s_flush),
    .id_ex_bubble_o  (s_bubble),
    .pipe_hold_o     (s_hold),
    .stall_cnt_o     (s_stall_cnt),
    .timeout_o       (s_timeout),
    .state_o         (s_state)
  );

  initial clk_i = 1'b1;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next active (falling) edge.
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic fl,
                        input logic st);
    id_ex_memread_i = mr;
    id_ex_rtaddr_i  = ex_rt;
    if_id_rsaddr_i  = rs;
    if_id_rtaddr_i  = rt;
    if_id_uses_rt_i = urt;
    flush_req_i     = fl;
    mem_stall_i     = st;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Decoded outputs packed as {pc_we, if_id_we, if_id_flush, bubble, pipe_hold}.
  task automatic expect_outs(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, pc_we_o, if_id_we_o, if_id_flush_o, id_ex_bubble_o, pipe_hold_o},
          {27'd0, exp});
  endtask

  initial begin
    rst_i = 1'b0;
    idle();

    // ---- reset: decoded outputs forced regardless of inputs
    set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
    expect_outs("rst_outs_busy_inputs", 5'b11000);
    tick();
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);

    rst_i = 1'b1;
    idle();
    expect_outs("run_idle", 5'b11000);
    tick();

    // ---- load-use on rs
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_outs("lu_rs", 5'b00010);
    tick();
    idle();
    expect_outs("lu_release", 5'b11000);
    check("lu_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);

    // ---- load-use on rt, gated by uses_rt
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    expect_outs("lu_rt_used", 5'b00010);
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    expect_outs("lu_rt_unused", 5'b11000);
    // ---- load into r0 never stalls
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    expect_outs("lu_r0", 5'b11000);
    // ---- load-use beats flush
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_outs("lu_over_flush", 5'b00010);
    // ---- plain flush
    set_in(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_outs("flush_only", 5'b11100);
    tick();
    check("flush_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);

    // ---- 4-cycle mem stall with a flush pulse in cycle 2
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_outs("ms_c1", 5'b00001);
    tick();
    check("ms_state_wait", {30'd0, state_o}, 32'd1);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    expect_outs("ms_c2_flush", 5'b00001);
    tick();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_outs("ms_c3", 5'b00001);
    tick();
    expect_outs("ms_c4", 5'b00001);
    tick();
    idle();
    expect_outs("ms_c5_wait_tail", 5'b00001);
    tick();
    check("ms_state_resume", {30'd0, state_o}, 32'd2);
    expect_outs("ms_resume_flush", 5'b11100);
    tick();
    check("ms_state_run", {30'd0, state_o}, 32'd0);
    expect_outs("ms_run_clear", 5'b11000);
    check("ms_stall_cnt", {16'd0, stall_cnt_o}, 32'd6);
    check("ms_small_timeout", {31'd0, s_timeout}, 32'd1);
    check("ms_big_timeout", {31'd0, timeout_o}, 32'd0);
    tick();

    // ---- mem stall, load-use and flush in the same cycle
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
    expect_outs("sim_all", 5'b00001);
    tick();
    idle();
    expect_outs("sim_wait_tail", 5'b00001);
    tick();
    expect_outs("sim_resume_pend", 5'b11100);
    tick();
    expect_outs("sim_run_clear", 5'b11000);
    check("sim_stall_cnt", {16'd0, stall_cnt_o}, 32'd8);
    tick();

    // ---- 300-cycle mem stall: watchdog boundary
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 255; i++) tick();
    check("to_before", {31'd0, timeout_o}, 32'd0);
    check("to_state_wait", {30'd0, state_o}, 32'd1);
    tick();
    check("to_rise", {31'd0, timeout_o}, 32'd1);
    for (int i = 0; i < 44; i++) tick();
    idle();
    tick();
    check("to_state_resume", {30'd0, state_o}, 32'd2);
    expect_outs("to_resume_noflush", 5'b11000);
    tick();
    check("to_sticky", {31'd0, timeout_o}, 32'd1);
    check("to_state_run", {30'd0, state_o}, 32'd0);
    check("to_stall_cnt", {16'd0, stall_cnt_o}, 32'd309);
    check("to_small_cnt_sat", {28'd0, s_stall_cnt}, 32'd15);

    // ---- reset in the middle of a stall
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("mr_state_wait", {30'd0, state_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    expect_outs("mr_outs_in_rst", 5'b11000);
    tick();
    check("mr_state", {30'd0, state_o}, 32'd0);
    check("mr_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check("mr_timeout", {31'd0, timeout_o}, 32'd0);
    rst_i = 1'b1;
    idle();
    expect_outs("mr_run", 5'b11000);
    tick();

    // ---- small instance: 2 MEM_WAIT cycles stays below TIMEOUT_CYC=3
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    tick();
    check("sb_state_resume", {30'd0, s_state}, 32'd2);
    check("sb_small_timeout_2", {31'd0, s_timeout}, 32'd0);
    tick();

    // ---- small instance: exactly 3 MEM_WAIT cycles trips it
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    idle();
    tick();
    check("sb_small_timeout_3", {31'd0, s_timeout}, 32'd1);
    check("sb_big_timeout", {31'd0, timeout_o}, 32'd0);
    tick();
    check("sb_stall_cnt", {16'd0, stall_cnt_o}, 32'd7);
    check("sb_small_cnt", {28'd0, s_stall_cnt}, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute guard so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the number of consecutive dcache-stall cycles after which timeout_o sets.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of stall_cnt_o.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on the falling edge, the same edge as the pipeline registers.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port id_ex_memread_i, input, 1, memory-read control bit of the ID/EX register (a load is in EX).
REQ-006 SHALL have port id_ex_rtaddr_i, input, 5, rt address held in ID/EX.
REQ-007 SHALL have ports if_id_rsaddr_i and if_id_rtaddr_i, input, 5 each, source register addresses decoded in ID.
REQ-008 SHALL have port if_id_uses_rt_i, input, 1, which is 1 when the ID instruction reads rt as a source.
REQ-009 SHALL have port flush_req_i, input, 1, a branch-taken or jump resolved in ID.
REQ-010 SHALL have port mem_stall_i, input, 1, dcache busy (miss or write-back in progress).
REQ-011 SHALL have port pc_we_o, output, 1, PC write enable.
REQ-012 SHALL have port if_id_we_o, output, 1, IF/ID write enable.
REQ-013 SHALL have port if_id_flush_o, output, 1, which zeroes the IF/ID instruction.
REQ-014 SHALL have port id_ex_bubble_o, output, 1, which forces the wb/mem/ex controls entering ID/EX to 0.
REQ-015 SHALL have port pipe_hold_o, output, 1, which freezes ID/EX, EX/MEM and MEM/WB.
REQ-016 SHALL have port stall_cnt_o, output, CNT_W, the count of cycles with pc_we_o=0.
REQ-017 SHALL have port timeout_o, output, 1, sticky dcache-stall timeout flag.
REQ-018 SHALL have port state_o, output, 2, the current FSM state encoding.

Function
REQ-019 SHALL define the load-use hazard lu = id_ex_memread_i & (id_ex_rtaddr_i != 0) & ((id_ex_rtaddr_i == if_id_rsaddr_i) | (if_id_uses_rt_i & (id_ex_rtaddr_i == if_id_rtaddr_i))).
REQ-020 SHALL implement FSM states RUN=0, MEM_WAIT=1, RESUME=2, with encoding 3 unused and returning to RUN on the next edge.
REQ-021 SHALL transition RUN->MEM_WAIT when mem_stall_i=1, MEM_WAIT->RESUME when mem_stall_i=0, RESUME->MEM_WAIT when mem_stall_i=1, and RESUME->RUN otherwise.
REQ-022 SHALL decode outputs combinationally from the current state and inputs, with priority mem stall > load-use > flush.
REQ-023 SHALL drive pipe_hold_o=1, pc_we_o=0, if_id_we_o=0, if_id_flush_o=0 and id_ex_bubble_o=0 whenever mem_stall_i=1 or state=MEM_WAIT.
REQ-024 SHALL, when there is no mem hold and lu=1, drive pc_we_o=0, if_id_we_o=0 and id_ex_bubble_o=1 for exactly that cycle, ignoring flush_req_i in that cycle.
REQ-025 SHALL, when there is no mem hold and lu=0, drive if_id_flush_o = flush_req_i | pend_flush, with pc_we_o=1 and if_id_we_o=1.
REQ-026 SHALL set the internal flag pend_flush when flush_req_i=1 during a mem hold, clear it in the first cycle that if_id_flush_o=1, and have it apply in RESUME.
REQ-027 SHALL increment the internal counter hold_cnt (8+ bits) each cycle in MEM_WAIT, clear it on leaving MEM_WAIT, and set timeout_o when hold_cnt reaches TIMEOUT_CYC; timeout_o clears only on reset.
REQ-028 SHALL increment stall_cnt_o on each edge where pc_we_o=0, saturating at all-ones with no wrap.
REQ-029 SHALL make all outputs purely decoded except the registered stall_cnt_o, timeout_o and state_o.

Reset
REQ-030 SHALL, on rst_i=0 at a falling edge, set state=RUN, pend_flush=0, hold_cnt=0, stall_cnt_o=0 and timeout_o=0, overriding any in-flight stall.
REQ-031 SHALL hold, while rst_i=0, pc_we_o=1, if_id_we_o=1, pipe_hold_o=0 and the other outputs at 0, regardless of inputs.

Verification
REQ-032 SHALL cover load-use: memread=1, id_ex_rt=5, if_id_rs=5 -> one cycle with pc_we_o=0, if_id_we_o=0, bubble=1; next cycle with memread=0 -> pc_we_o=1; stall_cnt_o=1.
REQ-033 SHALL cover rt=0: memread=1, id_ex_rt=0, if_id_rs=0 -> no stall, pc_we_o=1.
REQ-034 SHALL cover a 4-cycle mem stall: mem_stall_i=1 for 4 cycles with flush_req_i pulsed in cycle 2 -> pipe_hold_o=1 for 5 cycles, then a RESUME cycle with if_id_flush_o=1, then RUN.
REQ-035 SHALL cover simultaneous events: mem_stall_i=1, lu=1 and flush_req_i=1 in the same cycle -> only pipe_hold_o=1, bubble=0, pend_flush=1.
REQ-036 SHALL cover timeout: mem_stall_i held 300 cycles -> timeout_o rises after 255 MEM_WAIT cycles and stays 1 after the stall ends.
REQ-037 SHALL cover reset mid-stall: rst_i=0 in MEM_WAIT -> state_o=0, stall_cnt_o=0, timeout_o=0 at the next edge.
